// File: rtl/sync_pkg.sv
// Shared constants for the request conditioner: channel modes and pending states.
package sync_pkg;

  localparam logic [1:0] MODE_LEVEL  = 2'b00;
  localparam logic [1:0] MODE_RISE   = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [1:0] MODE_FALL   = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Edge event for a given mode from the filtered level and its one-cycle-old copy.
  function automatic logic edge_event(input logic [1:0] mode, input logic f, input logic f_prev);
    logic ev;
    ev = 1'b0;
    case (mode)
      MODE_RISE:   ev = f & ~f_prev;
      MODE_FALL:   ev = ~f & f_prev;
      MODE_TOGGLE: ev = f ^ f_prev;
      default:     ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/sync_filt_ch.sv
// One channel: synchronizer chain, glitch filter, edge detect, pending request and sticky overflow.
module sync_filt_ch
  import sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                async_i,
  input  logic                en_i,
  input  logic [1:0]          mode_i,
  input  logic [FILTER_W-1:0] filt_len_i,
  input  logic                ack_i,
  input  logic                ovf_clr_i,
  output logic                sync_o,
  output logic                req_o,
  output logic                ovf_o
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic [FILTER_W-1:0]    cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   fprev_q, fprev_d;
  logic [0:0]             state_q, state_d;
  logic                   req_q, req_d;
  logic                   ovf_q, ovf_d;
  logic                   raw;
  logic                   evt;
  logic                   ovf_set;

  assign raw = chain_q[SYNC_STAGES-1];

  // Synchronizer shift and glitch filter: the filtered level only follows raw after it has
  // disagreed for filt_len+1 consecutive cycles. Using >= keeps a shortened filt_len from
  // letting the counter run past it and wrap.
  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_i};
    cnt_d   = '0;
    filt_d  = filt_q;
    fprev_d = filt_q;
    if (raw != filt_q) begin
      if (cnt_q >= filt_len_i) begin
        filt_d = raw;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Pending FSM, overflow and registered request; LEVEL mode bypasses the FSM entirely.
  always_comb begin
    evt     = edge_event(mode_i, filt_q, fprev_q) & en_i;
    state_d = state_q;
    ovf_set = 1'b0;
    if (!en_i || mode_i == MODE_LEVEL) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (evt) state_d = ST_PEND;
    end else begin
      if (evt && !ack_i) ovf_set = 1'b1;
      else if (ack_i && !evt) state_d = ST_IDLE;
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
    if (mode_i == MODE_LEVEL) req_d = filt_q & en_i;
    else                      req_d = (state_d == ST_PEND);
  end

  // All channel state clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
      fprev_q <= 1'b0;
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      fprev_q <= fprev_d;
      state_q <= state_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sync_o = filt_q;
  assign req_o  = req_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/sync_req_cond.sv
// N-channel request conditioner: one sync_filt_ch per peripheral request line.
module sync_req_cond
  import sync_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 4
) (
  input  logic                ACLK_i,
  input  logic                axi_m_rstn_i,
  input  logic [NUM_CH-1:0]   async_i,
  input  logic [NUM_CH-1:0]   ch_en_i,
  input  logic [2*NUM_CH-1:0] ch_mode_i,
  input  logic [FILTER_W-1:0] filt_len_i,
  input  logic [NUM_CH-1:0]   ack_i,
  input  logic [NUM_CH-1:0]   ovf_clr_i,
  output logic [NUM_CH-1:0]   sync_o,
  output logic [NUM_CH-1:0]   req_o,
  output logic [NUM_CH-1:0]   ovf_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_filt_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_W   (FILTER_W)
    ) u_ch (
      .clk       (ACLK_i),
      .rst_n     (axi_m_rstn_i),
      .async_i   (async_i[c]),
      .en_i      (ch_en_i[c]),
      .mode_i    (ch_mode_i[2*c +: 2]),
      .filt_len_i(filt_len_i),
      .ack_i     (ack_i[c]),
      .ovf_clr_i (ovf_clr_i[c]),
      .sync_o    (sync_o[c]),
      .req_o     (req_o[c]),
      .ovf_o     (ovf_o[c])
    );
  end

endmodule

// File: tb/tb_sync_req_cond.sv
// Directed bench for sync_req_cond: per-cycle vector table plus hand-written corner sequences.
module tb_sync_req_cond;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] async_v, en, ack, clr;
  logic [7:0] mode;
  logic [3:0] filt;
  logic [3:0] sync_o, req_o, ovf_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] async_v;
    logic [3:0] ack;
    logic [3:0] exp_sync;
    logic [3:0] exp_req;
    logic [3:0] exp_ovf;
  } vec_t;

  vec_t tbl[11];

  sync_req_cond #(.NUM_CH(4), .SYNC_STAGES(2), .FILTER_W(4)) dut (
    .ACLK_i      (clk),
    .axi_m_rstn_i(rstn),
    .async_i     (async_v),
    .ch_en_i     (en),
    .ch_mode_i   (mode),
    .filt_len_i  (filt),
    .ack_i       (ack),
    .ovf_clr_i   (clr),
    .sync_o      (sync_o),
    .req_o       (req_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    async_v = '0; ack = '0; clr = '0;
    step(2);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; async_v = 4'hF; en = 4'h1; mode = 8'h55; filt = 4'd0; ack = '0; clr = '0;

    // Reset with inputs held high: outputs stay 0, then a RISE request appears 4 cycles after release.
    step(3);
    check("rst_sync", sync_o, 4'h0);
    check("rst_req", req_o, 4'h0);
    check("rst_ovf", ovf_o, 4'h0);
    rstn = 1'b1;
    step(3);
    check("rel_sync_c3", sync_o, 4'hF);
    check("rel_req_c3", req_o, 4'h0);
    step(1);
    check("rel_req_c4", req_o, 4'h1);

    // Table: ch0 RISE, filt_len 0, ack at cycle 6, then the input falls (no event in RISE).
    tbl[0]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[3]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
    tbl[4]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
    tbl[5]  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
    tbl[6]  = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[7]  = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[8]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[9]  = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    do_reset();
    en = 4'h1; mode = 8'h55; filt = 4'd0;
    for (int i = 0; i < 11; i++) begin
      async_v = tbl[i].async_v;
      ack     = tbl[i].ack;
      step(1);
      check($sformatf("tbl%0d_sync", i), sync_o, tbl[i].exp_sync);
      check($sformatf("tbl%0d_req", i), req_o, tbl[i].exp_req);
      check($sformatf("tbl%0d_ovf", i), ovf_o, tbl[i].exp_ovf);
    end
    ack = '0;

    // Glitch filter, filt_len 3: a 2-cycle pulse is dropped, a long pulse passes at cycle 6.
    do_reset();
    en = 4'h1; mode = 8'h55; filt = 4'd3;
    async_v = 4'h1;
    step(2);
    async_v = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch_sync", sync_o, 4'h0);
      check("glitch_req", req_o, 4'h0);
    end
    async_v = 4'h1;
    step(5);
    check("filt_sync_c5", sync_o, 4'h0);
    step(1);
    check("filt_sync_c6", sync_o, 4'h1);
    check("filt_req_c6", req_o, 4'h0);
    step(1);
    check("filt_req_c7", req_o, 4'h1);
    step(3);
    async_v = 4'h0;
    filt = 4'd0;

    // ch1 TOGGLE: second toggle without ack sets overflow; clear pulse drops it, request kept.
    do_reset();
    en = 4'h2; mode = 8'hAA; filt = 4'd0;
    async_v = 4'h2;
    step(4);
    check("tog_req1", req_o, 4'h2);
    check("tog_ovf0", ovf_o, 4'h0);
    step(6);
    async_v = 4'h0;
    step(5);
    check("tog_req2", req_o, 4'h2);
    check("tog_ovf1", ovf_o, 4'h2);
    clr = 4'h2;
    step(1);
    clr = 4'h0;
    check("tog_ovf_clr", ovf_o, 4'h0);
    check("tog_req_kept", req_o, 4'h2);

    // ch2 FALL: rising edge ignored; a fall coinciding with ack keeps the request, no overflow.
    do_reset();
    en = 4'h4; mode = 8'hFF; filt = 4'd0;
    async_v = 4'h4;
    step(6);
    check("fall_sync_hi", sync_o, 4'h4);
    check("fall_no_req", req_o, 4'h0);
    async_v = 4'h0;
    step(4);
    check("fall_req", req_o, 4'h4);
    async_v = 4'h4;
    step(6);
    async_v = 4'h0;
    step(3);
    ack = 4'h4;
    step(1);
    ack = 4'h0;
    check("fall_ack_req", req_o, 4'h4);
    check("fall_ack_ovf", ovf_o, 4'h0);
    ack = 4'h4;
    step(1);
    ack = 4'h0;
    check("fall_acked", req_o, 4'h0);

    // ch3: disabled while input rises gives no stale request; LEVEL follows sync_o one cycle late.
    do_reset();
    en = 4'h0; mode = 8'h40; filt = 4'd0;
    async_v = 4'h8;
    step(8);
    check("dis_sync", sync_o, 4'h8);
    check("dis_req", req_o, 4'h0);
    en = 4'h8;
    step(5);
    check("en_no_req", req_o, 4'h0);
    check("en_no_ovf", ovf_o, 4'h0);
    mode = 8'h00;
    step(1);
    check("lvl_req", req_o, 4'h8);
    ack = 4'h8;
    step(1);
    ack = 4'h0;
    check("lvl_ack_ign", req_o, 4'h8);
    async_v = 4'h0;
    step(3);
    check("lvl_sync_lo", sync_o, 4'h0);
    check("lvl_req_lag", req_o, 4'h8);
    step(1);
    check("lvl_req_lo", req_o, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
